debug_trace: RTL and testbench
==============================

Name: debug_trace

Overview:
- Parametrised bus-trace debugger. While armed, it captures REC_W-bit snapshots into a DEPTH-entry ring buffer, one snapshot per sample_en cycle. The snapshots carry fields such as addr, data, pc and strobes, packed by the instantiating top level.
- On a trigger rising edge it freezes the buffer. It then dumps the entries oldest-first as uppercase ASCII hex lines (CR LF terminated) over an integrated 8N1 UART.
- Sits beside the CPU/PPU in the top level and drives the board's debug tx pin.

Parameters:
- DEPTH, 16, ring buffer entries; power of two, >= 2.
- REC_W, 40, record width in bits; multiple of 4, 4..64.
- BAUD_DIV, 104, clk cycles per UART bit; >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sample_en  input  1  capture sample this cycle (armed only).
- sample  input  REC_W  snapshot data.
- trigger  input  1  dump request; rising edge significant.
- arm  input  1  single-cycle pulse; clears buffer and re-arms.
- tx  output  1  UART serial out, idle high.
- busy  output  1  high while dumping.
- count  output  $clog2(DEPTH+1)  valid entries held.
- wrapped  output  1  at least one entry overwritten since last arm.

Behaviour:
- Reset (async, immediate, any state): state ARMED, wr_ptr=0, count=0, wrapped=0, busy=0, tx=1, trigger_q=0, UART idle.
- trig_edge = trigger & ~trigger_q. trigger_q is registered every cycle.

States:
- ARMED: on sample_en, mem[wr_ptr]<=sample and wr_ptr<=wr_ptr+1 mod DEPTH.
  - count increments, saturating at DEPTH.
  - Writing while count==DEPTH sets wrapped.
  - arm clears wr_ptr, count and wrapped; arm has priority over sample_en in the same cycle.
  - On trig_edge: any sample_en in the same cycle is still captured.
  - After trig_edge with resulting count==0: go to IDLE, no output, busy stays 0.
  - After trig_edge with count>0: rd_ptr <= (wr_ptr_new - count_new) mod DEPTH, rec_left <= count_new, busy<=1, go to LOAD.
- LOAD: shift_reg <= mem[rd_ptr], nib_left <= REC_W/4, go to HEX.
- HEX: send hex char of shift_reg's top nibble (0-9 -> 0x30-0x39, A-F -> 0x41-0x46).
  - After each char is accepted: shift left 4, nib_left--.
  - When nib_left reaches 0: go to CR.
- CR: send 0x0D. LF: send 0x0A.
- After LF, rd_ptr++ mod DEPTH and rec_left--. If rec_left>0, go to LOAD; else go to DRAIN.
- DRAIN: wait for the UART to finish the stop bit, then busy<=0 and go to IDLE.
- IDLE: no capture. trigger ignored. arm clears wr_ptr/count/wrapped and goes to ARMED.
- arm, trigger and sample_en are ignored during LOAD/HEX/CR/LF/DRAIN. Buffer contents and count are unchanged by a dump.

UART:
- Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit held exactly BAUD_DIV cycles.
- Next frame's start bit begins at most 2 clk cycles after the previous stop bit ends. Total dump time is therefore at most (frames*(10*BAUD_DIV+2)+DEPTH*2+4) cycles.
- Frames per record = REC_W/4 + 2.
- tx is registered (glitch-free).

Test Plan:
- Reset with DEPTH=4, REC_W=16, BAUD_DIV=4 -> tx=1, busy=0, count=0, wrapped=0; toggle trigger -> no frames.
- Capture 0x1234, 0xABCD, 0x00FF, then trigger rise -> count=3, busy high. UART decodes "1234\r\nABCD\r\n00FF\r\n" (18 frames, 40 cycles each); busy falls after the last stop bit; state IDLE.
- Capture 0x0001..0x0006 -> count=4, wrapped=1; dump decodes "0003\r\n0004\r\n0005\r\n0006\r\n".
- sample_en with 0xBEEF in the same cycle as trig_edge, after 0x0001 -> dump "0001\r\nBEEF\r\n".
- During a dump: pulse arm, assert sample_en, re-toggle trigger -> output unchanged, count unchanged. Afterwards arm in IDLE -> count=0, wrapped=0, capture resumes.
- Assert reset mid-frame -> tx=1 and busy=0 immediately (asynchronously), count=0; the next capture and trigger produce a clean dump.

Source files
------------

// File: rtl/debug_trace_if.sv
// Trace port bundle between the instantiating top level and the bus-trace debugger.
// The master side supplies snapshots and control; the slave side returns UART and status.
interface debug_trace_if #(
   parameter int DEPTH = 16,
   parameter int REC_W = 40
);
   logic                         sample_en;
   logic [REC_W-1:0]             sample;
   logic                         trigger;
   logic                         arm;
   logic                         tx;
   logic                         busy;
   logic [$clog2(DEPTH+1)-1:0]   count;
   logic                         wrapped;

   modport master (
      output sample_en, sample, trigger, arm,
      input  tx, busy, count, wrapped
   );

   modport slave (
      input  sample_en, sample, trigger, arm,
      output tx, busy, count, wrapped
   );
endinterface

// File: rtl/debug_trace.sv
// Ring-buffer bus tracer: captures snapshots while armed, freezes on a trigger edge,
// then dumps the entries oldest-first as ASCII hex lines over a built-in 8N1 UART.
module debug_trace #(
   parameter int DEPTH    = 16,
   parameter int REC_W    = 40,
   parameter int BAUD_DIV = 104
) (
   input  logic         clk,
   input  logic         reset,
   debug_trace_if.slave bus
);
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH+1);
   localparam int NIB = REC_W / 4;
   localparam int NW  = $clog2(NIB+1);
   localparam int BW  = $clog2(BAUD_DIV);

   typedef enum logic [2:0] {ARMED, IDLE, LOAD, HEX, CR, LF, DRAIN} state_t;

   state_t            state_reg;
   logic [REC_W-1:0]  mem [DEPTH];
   logic [PW-1:0]     wr_ptr_reg;
   logic [PW-1:0]     rd_ptr_reg;
   logic [CW-1:0]     count_reg;
   logic [CW-1:0]     rec_left_reg;
   logic              wrapped_reg;
   logic              busy_reg;
   logic              trigger_q;
   logic [REC_W-1:0]  shift_reg;
   logic [NW-1:0]     nib_left_reg;
   logic              char_valid_reg;
   logic [7:0]        char_reg;

   logic              uart_active_reg;
   logic              tx_reg;
   logic [BW-1:0]     baud_cnt_reg;
   logic [3:0]        bit_idx_reg;
   logic [8:0]        frame_reg;

   logic              trig_edge;
   logic              do_write;
   logic              accept;
   logic [PW-1:0]     wr_ptr_next;
   logic [CW-1:0]     count_next;
   logic              wrapped_next;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   assign trig_edge = bus.trigger & ~trigger_q;
   assign accept    = char_valid_reg & ~uart_active_reg;

   // Capture bookkeeping as it would look after this cycle; arm wins over sample_en.
   always_comb begin
      wr_ptr_next  = wr_ptr_reg;
      count_next   = count_reg;
      wrapped_next = wrapped_reg;
      do_write     = 1'b0;
      if (bus.arm) begin
         wr_ptr_next  = '0;
         count_next   = '0;
         wrapped_next = 1'b0;
      end else if (bus.sample_en) begin
         do_write    = 1'b1;
         wr_ptr_next = wr_ptr_reg + 1'b1;
         if (count_reg == CW'(DEPTH))
            wrapped_next = 1'b1;
         else
            count_next = count_reg + 1'b1;
      end
      if (state_reg != ARMED)
         do_write = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (do_write)
         mem[wr_ptr_reg] <= bus.sample;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ARMED;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         rec_left_reg   <= '0;
         wrapped_reg    <= 1'b0;
         busy_reg       <= 1'b0;
         trigger_q      <= 1'b0;
         shift_reg      <= '0;
         nib_left_reg   <= '0;
         char_valid_reg <= 1'b0;
         char_reg       <= 8'h00;
      end else begin
         trigger_q <= bus.trigger;
         case (state_reg)
            ARMED: begin
               wr_ptr_reg  <= wr_ptr_next;
               count_reg   <= count_next;
               wrapped_reg <= wrapped_next;
               if (trig_edge) begin
                  if (count_next == '0) begin
                     state_reg <= IDLE;
                  end else begin
                     // Oldest entry sits count_next slots behind the write pointer.
                     rd_ptr_reg   <= wr_ptr_next - count_next[PW-1:0];
                     rec_left_reg <= count_next;
                     busy_reg     <= 1'b1;
                     state_reg    <= LOAD;
                  end
               end
            end
            IDLE: begin
               if (bus.arm) begin
                  wr_ptr_reg  <= '0;
                  count_reg   <= '0;
                  wrapped_reg <= 1'b0;
                  state_reg   <= ARMED;
               end
            end
            LOAD: begin
               shift_reg    <= mem[rd_ptr_reg];
               nib_left_reg <= NW'(NIB);
               state_reg    <= HEX;
            end
            HEX: begin
               if (accept) begin
                  char_valid_reg <= 1'b0;
                  shift_reg      <= shift_reg << 4;
                  nib_left_reg   <= nib_left_reg - 1'b1;
                  if (nib_left_reg == NW'(1))
                     state_reg <= CR;
               end else if (!char_valid_reg) begin
                  char_valid_reg <= 1'b1;
                  char_reg       <= hex_char(shift_reg[REC_W-1 -: 4]);
               end
            end
            CR: begin
               if (accept) begin
                  char_valid_reg <= 1'b0;
                  state_reg      <= LF;
               end else if (!char_valid_reg) begin
                  char_valid_reg <= 1'b1;
                  char_reg       <= 8'h0D;
               end
            end
            LF: begin
               if (accept) begin
                  char_valid_reg <= 1'b0;
                  rd_ptr_reg     <= rd_ptr_reg + 1'b1;
                  rec_left_reg   <= rec_left_reg - 1'b1;
                  state_reg      <= (rec_left_reg == CW'(1)) ? DRAIN : LOAD;
               end else if (!char_valid_reg) begin
                  char_valid_reg <= 1'b1;
                  char_reg       <= 8'h0A;
               end
            end
            DRAIN: begin
               if (!uart_active_reg && !char_valid_reg) begin
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= ARMED;
         endcase
      end
   end

   // 8N1 transmitter; frame_reg holds the bits still to go, stop bit on top.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uart_active_reg <= 1'b0;
         tx_reg          <= 1'b1;
         baud_cnt_reg    <= '0;
         bit_idx_reg     <= 4'd0;
         frame_reg       <= '1;
      end else if (!uart_active_reg) begin
         if (char_valid_reg) begin
            uart_active_reg <= 1'b1;
            frame_reg       <= {1'b1, char_reg};
            tx_reg          <= 1'b0;
            baud_cnt_reg    <= '0;
            bit_idx_reg     <= 4'd0;
         end
      end else if (baud_cnt_reg == BW'(BAUD_DIV-1)) begin
         baud_cnt_reg <= '0;
         if (bit_idx_reg == 4'd9) begin
            uart_active_reg <= 1'b0;
         end else begin
            bit_idx_reg <= bit_idx_reg + 4'd1;
            tx_reg      <= frame_reg[0];
            frame_reg   <= {1'b1, frame_reg[8:1]};
         end
      end else begin
         baud_cnt_reg <= baud_cnt_reg + 1'b1;
      end
   end

   assign bus.tx      = tx_reg;
   assign bus.busy    = busy_reg;
   assign bus.count   = count_reg;
   assign bus.wrapped = wrapped_reg;
endmodule

// File: tb/tb_debug_trace.sv
// Randomized bench for debug_trace: a queue-based ring model predicts the hex dump text,
// and a time-based UART receiver decodes tx for comparison.
module tb_debug_trace;
   localparam int DEPTH    = 4;
   localparam int REC_W    = 16;
   localparam int BAUD_DIV = 4;
   localparam int NIB      = REC_W / 4;
   localparam int BIT_NS   = BAUD_DIV * 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   debug_trace_if #(.DEPTH(DEPTH), .REC_W(REC_W)) bus ();

   debug_trace #(.DEPTH(DEPTH), .REC_W(REC_W), .BAUD_DIV(BAUD_DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [9:0]       rx_q[$];
   logic [9:0]       rx_frame;
   logic [7:0]       exp_q[$];
   logic [REC_W-1:0] model_q[$];
   int               model_total = 0;
   string            hexd = "0123456789ABCDEF";

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Receiver samples mid-bit, away from clock edges; frame kept as {stop, data, start}.
   initial begin
      forever begin
         @(negedge bus.tx);
         #(BIT_NS/2 + 5);
         rx_frame[0] = bus.tx;
         for (int i = 1; i < 10; i++) begin
            #(BIT_NS);
            rx_frame[i] = bus.tx;
         end
         rx_q.push_back(rx_frame);
      end
   end

   task automatic model_clear();
      model_q.delete();
      model_total = 0;
   endtask

   task automatic model_push(input logic [REC_W-1:0] v);
      model_q.push_back(v);
      model_total++;
      if (model_q.size() > DEPTH)
         void'(model_q.pop_front());
   endtask

   task automatic build_exp();
      logic [REC_W-1:0] rec;
      logic [3:0]       nib;
      exp_q.delete();
      foreach (model_q[r]) begin
         rec = model_q[r];
         for (int k = NIB-1; k >= 0; k--) begin
            nib = rec[4*k +: 4];
            exp_q.push_back(8'(hexd[nib]));
         end
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endtask

   task automatic capture(input logic [REC_W-1:0] v);
      @(negedge clk);
      bus.sample_en = 1'b1;
      bus.sample    = v;
      @(negedge clk);
      bus.sample_en = 1'b0;
      model_push(v);
   endtask

   task automatic do_arm();
      @(negedge clk);
      bus.arm = 1'b1;
      @(negedge clk);
      bus.arm = 1'b0;
      model_clear();
   endtask

   task automatic run_dump(input string tag, input bit with_sample,
                           input logic [REC_W-1:0] extra, input bit meddle);
      int   cyc;
      int   bound;
      int   exp_cnt;
      logic exp_wr;
      rx_q.delete();
      @(negedge clk);
      bus.trigger = 1'b1;
      if (with_sample) begin
         bus.sample_en = 1'b1;
         bus.sample    = extra;
         model_push(extra);
      end
      build_exp();
      exp_cnt = model_q.size();
      exp_wr  = (model_total > DEPTH);
      bound   = exp_q.size() * (10*BAUD_DIV + 2) + DEPTH*2 + 4;
      @(negedge clk);
      bus.sample_en = 1'b0;
      check({tag, "_busy_on"}, bus.busy, exp_cnt != 0);
      check({tag, "_count"}, bus.count, exp_cnt);
      cyc = 1;
      if (exp_cnt == 0) begin
         repeat (60) @(negedge clk);
      end else begin
         while (bus.busy && cyc < bound + 100) begin
            if (meddle && cyc == 30) begin
               bus.arm       = 1'b1;
               bus.sample_en = 1'b1;
               bus.sample    = REC_W'($urandom);
               bus.trigger   = 1'b0;
            end else if (meddle && cyc == 31) begin
               bus.arm       = 1'b0;
               bus.sample_en = 1'b0;
               bus.trigger   = 1'b1;
            end
            @(negedge clk);
            cyc++;
         end
         check({tag, "_dump_time_ok"}, cyc <= bound, 1);
      end
      check({tag, "_busy_off"}, bus.busy, 0);
      check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), rx_q[i], {1'b1, exp_q[i], 1'b0});
      bus.trigger = 1'b0;
      @(negedge clk);
      check({tag, "_count_after"}, bus.count, exp_cnt);
      check({tag, "_wrapped_after"}, bus.wrapped, exp_wr);
      $display("dump %s: %0d records, %0d bytes expected, %0d received, %0d cycles",
               tag, exp_cnt, exp_q.size(), rx_q.size(), cyc);
   endtask

   initial begin
      int n;
      bus.sample_en = 1'b0;
      bus.sample    = '0;
      bus.trigger   = 1'b0;
      bus.arm       = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", bus.tx, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_count", bus.count, 0);
      check("rst_wrapped", bus.wrapped, 0);
      reset = 1'b0;
      @(negedge clk);

      // Empty-buffer trigger: no frames; IDLE then ignores capture until armed.
      run_dump("empty", 1'b0, '0, 1'b0);
      capture(16'h5555);
      model_clear();
      check("idle_no_capture", bus.count, 0);
      do_arm();

      capture(16'h1234);
      capture(16'hABCD);
      capture(16'h00FF);
      run_dump("three", 1'b0, '0, 1'b0);

      do_arm();
      for (int v = 1; v <= 6; v++) capture(REC_W'(v));
      check("wrap_count", bus.count, 4);
      check("wrap_flag", bus.wrapped, 1);
      run_dump("wrap", 1'b0, '0, 1'b0);

      do_arm();
      capture(16'h0001);
      run_dump("same_cycle", 1'b1, 16'hBEEF, 1'b0);

      do_arm();
      capture(16'hC0DE);
      capture(16'h7A3F);
      run_dump("meddle", 1'b0, '0, 1'b1);
      do_arm();
      check("rearm_count", bus.count, 0);
      check("rearm_wrapped", bus.wrapped, 0);
      capture(16'h4242);
      check("resume_count", bus.count, 1);

      for (int r = 0; r < 8; r++) begin
         do_arm();
         n = $urandom_range(0, 9);
         for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            capture(REC_W'($urandom));
         end
         run_dump($sformatf("rand%0d", r), 1'b0, '0, 1'b0);
      end

      // Asynchronous reset in the middle of a frame.
      do_arm();
      capture(16'h0F0F);
      capture(16'h9999);
      @(negedge clk);
      bus.trigger = 1'b1;
      repeat (20) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_tx", bus.tx, 1);
      check("arst_busy", bus.busy, 0);
      check("arst_count", bus.count, 0);
      bus.trigger = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #(BIT_NS * 12);
      @(negedge clk);
      rx_q.delete();
      model_clear();
      capture(16'hFACE);
      capture(16'h0420);
      run_dump("post_reset", 1'b0, '0, 1'b0);
      check("final_tx_idle", bus.tx, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
